// File: rtl/da_inner_product_pkg.sv
// Shared types and sizing for the distributed-arithmetic inner-product engine.
// Consumers size their result buses with da_ow() so they match dout.
package da_inner_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } da_state_e;

  // Result width: product width plus growth for summing k terms.
  function automatic int da_ow(input int w, input int cw, input int k);
    return w + cw + $clog2(k);
  endfunction

endpackage

// File: rtl/da_inner_product_shift_reg.sv
// Parallel-load, LSB-first serial-out shift register with shift enable.
module shift_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         pl,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic         so
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   q <= '0;
    else if (pl) q <= d;
    else if (en) q <= q >> 1;
  end

  assign so = q[0];

endmodule

// File: rtl/da_inner_product.sv
// Bit-serial DA inner product: y = sum(c_i * x_i), one x bit-slice per enabled
// cycle, LSB first, with valid/ready on both sides and a stall input.
module da_inner_product
  import da_inner_product_pkg::*;
#(
  parameter int W      = 5,
  parameter int K      = 4,
  parameter int CW     = 4,
  parameter int SIGNED = 0,
  localparam int OW    = da_ow(W, CW, K)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*K-1:0]  din,
  input  logic [CW*K-1:0] coef,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   dout,
  output logic            busy
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int NL = 1 << K;

  da_state_e state, state_nxt;
  logic                 accept, step, last;
  logic [BW-1:0]        bcnt;
  logic [OW-1:0]        acc, acc_nxt, term;
  logic [K-1:0]         addr;
  logic [K-1:0][CW-1:0] coef_q;
  logic [OW-1:0]        lut [NL];

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign step      = (state == ST_RUN) && enable;
  assign last      = (bcnt == BW'(W - 1));
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN);

  for (genvar g = 0; g < K; g++) begin : g_sr
    shift_reg #(.W(W)) u_sr (
      .clk  (clk),
      .rstn (rstn),
      .pl   (accept),
      .en   (step),
      .d    (din[g*W +: W]),
      .so   (addr[g])
    );
  end

  function automatic logic [OW-1:0] ext(input logic [CW-1:0] c);
    if (SIGNED != 0) return {{(OW-CW){c[CW-1]}}, c};
    else             return {{(OW-CW){1'b0}}, c};
  endfunction

  // Every subset sum of the latched coefficients, indexed by the bit-slice.
  always_comb begin
    for (int a = 0; a < NL; a++) begin
      lut[a] = '0;
      for (int i = 0; i < K; i++)
        if (a[i]) lut[a] = lut[a] + ext(coef_q[i]);
    end
  end

  // The MSB slice carries negative weight in two's complement.
  assign term    = lut[addr] << bcnt;
  assign acc_nxt = (SIGNED != 0 && last) ? acc - term : acc + term;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (step && last) state_nxt = ST_DONE;
      ST_DONE: begin
        if (accept)         state_nxt = ST_RUN;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      bcnt   <= '0;
      dout   <= '0;
      coef_q <= '0;
    end else if (accept) begin
      coef_q <= coef;
      acc    <= '0;
      bcnt   <= '0;
    end else if (step) begin
      acc  <= acc_nxt;
      bcnt <= bcnt + 1'b1;
      if (last) dout <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_da_inner_product.sv
// Bench for da_inner_product: unsigned and signed instances driven in parallel,
// checked against a plain-arithmetic dot-product model.
module tb_da_inner_product;

  logic        clk = 0;
  logic        rstn = 0;
  logic        enable = 1;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [19:0] din = '0;
  logic [15:0] coef = '0;
  logic        in_ready_u, out_valid_u, busy_u;
  logic        in_ready_s, out_valid_s, busy_s;
  logic [10:0] dout_u, dout_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  da_inner_product #(.W(5), .K(4), .CW(4), .SIGNED(0)) dut_u (
    .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready_u), .din(din), .coef(coef), .out_valid(out_valid_u),
    .out_ready(out_ready), .dout(dout_u), .busy(busy_u));

  da_inner_product #(.W(5), .K(4), .CW(4), .SIGNED(1)) dut_s (
    .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready_s), .din(din), .coef(coef), .out_valid(out_valid_s),
    .out_ready(out_ready), .dout(dout_s), .busy(busy_s));

  function automatic int ref_dot(input logic [19:0] d, input logic [15:0] c, input bit sgn);
    int s, x, k;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = int'(d[i*5 +: 5]);
      k = int'(c[i*4 +: 4]);
      if (sgn) begin
        if (x >= 16) x -= 32;
        if (k >= 8)  k -= 16;
      end
      s += x * k;
    end
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input string nm, input logic [19:0] d, input logic [15:0] c,
                         input bit stall, input bit bp);
    int n, nb, bad, eu, es;
    logic [10:0] hold;
    eu = ref_dot(d, c, 0);
    es = ref_dot(d, c, 1);
    @(negedge clk);
    din = d; coef = c; in_valid = 1; out_ready = 0; enable = 1;
    chk({nm, " in_ready"}, int'(in_ready_u), 1);
    @(negedge clk);
    in_valid = 0;
    n = 0; nb = 0;
    while (!out_valid_u && n < 40) begin
      if (busy_u) nb++;
      if (stall && n == 2) enable = 0;
      if (stall && n == 5) enable = 1;
      @(negedge clk);
      n++;
    end
    enable = 1;
    chk({nm, " latency"}, n, stall ? 8 : 5);
    chk({nm, " busy_cycles"}, nb, stall ? 8 : 5);
    chk({nm, " dout_u"}, int'(dout_u), eu);
    chk({nm, " dout_s"}, int'($signed(dout_s)), es);
    if (bp) begin
      hold = dout_u; bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (!out_valid_u || in_ready_u || dout_u !== hold) bad++;
      end
      chk({nm, " backpressure_hold"}, bad, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, " out_valid_after_hs"}, int'(out_valid_u), 0);
    chk({nm, " dout_kept"}, int'(dout_u), eu);
  endtask

  typedef struct {
    logic [19:0] d;
    logic [15:0] c;
    int          eu;
    int          es;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [19:0] jd[3];
    logic [15:0] jc[3];
    int          got_t[$];
    int          got_u[$];
    int          got_s[$];
    int          idx;
    bit          rdy;

    tbl[0] = '{ {5'd4, 5'd3, 5'd2, 5'd1},    {4'd1, 4'd1, 4'd1, 4'd1},  10,  10};
    tbl[1] = '{ {5'd31, 5'd31, 5'd31, 5'd31}, {4'd15, 4'd15, 4'd15, 4'd15}, 1860, 4};
    tbl[2] = '{ {5'd31, 5'd0, 5'd3, 5'd16},  {4'd1, 4'd7, 4'd2, 4'd8}, 165, 133};
    tbl[3] = '{ {5'd16, 5'd16, 5'd16, 5'd16}, {4'd8, 4'd8, 4'd8, 4'd8}, 512, 512};

    repeat (3) @(negedge clk);
    chk("reset in_ready", int'(in_ready_u & in_ready_s), 1);
    chk("reset out_valid", int'(out_valid_u | out_valid_s), 0);
    chk("reset busy", int'(busy_u | busy_s), 0);
    chk("reset dout", int'(dout_u | dout_s), 0);
    rstn = 1;

    for (int v = 0; v < 4; v++) begin
      chk($sformatf("tbl%0d model_u", v), ref_dot(tbl[v].d, tbl[v].c, 0), tbl[v].eu);
      chk($sformatf("tbl%0d model_s", v), ref_dot(tbl[v].d, tbl[v].c, 1), tbl[v].es);
      run_job($sformatf("tbl%0d", v), tbl[v].d, tbl[v].c, 0, 0);
    end

    run_job("stall", tbl[0].d, tbl[0].c, 1, 0);
    run_job("backpressure", tbl[1].d, tbl[1].c, 0, 1);

    for (int r = 0; r < 20; r++)
      run_job($sformatf("rand%0d", r), 20'($urandom), 16'($urandom), 0, 0);

    // Back-to-back: in_valid and out_ready held high across three jobs.
    for (int j = 0; j < 3; j++) begin
      jd[j] = 20'($urandom);
      jc[j] = 16'($urandom);
    end
    @(negedge clk);
    idx = 0; din = jd[0]; coef = jc[0]; in_valid = 1; out_ready = 1; enable = 1;
    for (int t = 0; t < 40; t++) begin
      rdy = in_ready_u && in_valid;
      if (out_valid_u) begin
        got_t.push_back(t);
        got_u.push_back(int'(dout_u));
        got_s.push_back(int'($signed(dout_s)));
      end
      @(negedge clk);
      if (rdy) begin
        idx++;
        if (idx < 3) begin din = jd[idx]; coef = jc[idx]; end
        else in_valid = 0;
      end
    end
    out_ready = 0;
    chk("b2b result_count", got_u.size(), 3);
    for (int j = 0; j < 3; j++) begin
      if (got_u.size() > j) begin
        chk($sformatf("b2b%0d dout_u", j), got_u[j], ref_dot(jd[j], jc[j], 0));
        chk($sformatf("b2b%0d dout_s", j), got_s[j], ref_dot(jd[j], jc[j], 1));
        if (j > 0) chk($sformatf("b2b%0d spacing", j), got_t[j] - got_t[j-1], 6);
      end
    end

    // Reset two slices into a job; the previous result in dout must clear.
    @(negedge clk);
    din = 20'($urandom); coef = 16'($urandom); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset busy", int'(busy_u), 1);
    rstn = 0;
    #1;
    chk("midrun_reset out_valid", int'(out_valid_u | out_valid_s), 0);
    chk("midrun_reset in_ready", int'(in_ready_u & in_ready_s), 1);
    chk("midrun_reset dout", int'(dout_u | dout_s), 0);
    chk("midrun_reset busy", int'(busy_u | busy_s), 0);
    @(negedge clk);
    rstn = 1;
    run_job("post_reset", tbl[2].d, tbl[2].c, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
